// File: rtl/frame_dump_mgr.sv
// Multi-buffer frame dumper: packs data-channel bytes into RAM words, one frame per dumpMem.
// Optional macro HANDSHAKE_SYNC_EN adds a 2-flop synchronizer on handshakePC.
module frame_dump_mgr #(
  parameter int BYTE_W = 8,
  parameter int BPW    = 4,
  parameter int ADDR_W = 8,
  parameter int BUF_W  = 1,
  localparam int NUM_BUF = 1 << BUF_W,
  localparam int WORD_W  = BYTE_W * BPW
) (
  input  logic                    SYSCLK,
  input  logic                    reset_n,
  input  logic                    dumpMem,
  input  logic                    write_En_datachannel,
  input  logic [BYTE_W-1:0]       data_datachannel,
  input  logic [ADDR_W-1:0]       frame_words,
  input  logic [NUM_BUF-1:0]      handshakePC,
  output logic [NUM_BUF-1:0]      handshakeFPGA,
  output logic [WORD_W-1:0]       IPbus_RAM_data,
  output logic [BUF_W+ADDR_W-1:0] IPbus_RAM_address,
  output logic                    IPbus_RAM_we,
  output logic                    dumpdone,
  output logic                    busy,
  output logic                    trashing,
  output logic [15:0]             dropped_frames
);

  localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int BUF_WI = (BUF_W > 0) ? BUF_W : 1;

  typedef enum logic [1:0] {IDLE, DUMPING, TRASH, STOPDUMP} state_t;

  state_t                   state_r, state_s;
  logic [NUM_BUF-1:0]       hs_pc_s;
  logic [NUM_BUF-1:0]       hs_fpga_r;
  logic [BUF_WI-1:0]        wr_buf_r, wr_buf_nxt_s;
  logic [BCW-1:0]           byte_cnt_r;
  logic [ADDR_W-1:0]        word_cnt_r, len_r, len_m1_s;
  logic [WORD_W-1:0]        shift_r, packed_s;
  logic [BUF_W+ADDR_W-1:0]  addr_s;
  logic                     end_pending_r, buf_free_s, active_s;
  logic                     we_r, dumpdone_r, busy_r, trashing_r;
  logic [WORD_W-1:0]        data_r;
  logic [BUF_W+ADDR_W-1:0]  addr_r;
  logic [15:0]              dropped_r;

`ifdef HANDSHAKE_SYNC_EN
  logic [NUM_BUF-1:0] hs_sync1_r, hs_sync2_r;

  // Two-flop synchronizer for the PC-side toggle bits
  always_ff @(posedge SYSCLK or negedge reset_n) begin
    if (!reset_n) begin
      hs_sync1_r <= '0;
      hs_sync2_r <= '0;
    end else begin
      hs_sync1_r <= handshakePC;
      hs_sync2_r <= hs_sync1_r;
    end
  end
  assign hs_pc_s = hs_sync2_r;
`else
  assign hs_pc_s = handshakePC;
`endif

  generate
    if (BUF_W > 0) begin : g_multi
      assign addr_s       = {wr_buf_r, word_cnt_r};
      assign wr_buf_nxt_s = wr_buf_r + BUF_WI'(1);
    end else begin : g_single
      assign addr_s       = word_cnt_r;
      assign wr_buf_nxt_s = '0;
    end
  endgenerate

  assign buf_free_s = (hs_fpga_r[wr_buf_r] == hs_pc_s[wr_buf_r]);
  assign packed_s   = (shift_r << BYTE_W) | WORD_W'(data_datachannel);
  // len==0 wraps to all-ones, i.e. the full buffer
  assign len_m1_s   = len_r - ADDR_W'(1);
  assign active_s   = ((state_r == DUMPING) || (state_r == TRASH)) && !end_pending_r;

  // State register
  always_ff @(posedge SYSCLK or negedge reset_n) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (dumpMem) state_s = buf_free_s ? DUMPING : TRASH;
        else         state_s = IDLE;
      end
      DUMPING, TRASH: begin
        if (end_pending_r) state_s = STOPDUMP;
        else               state_s = state_r;
      end
      STOPDUMP: state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // Packing, word writes, frame completion and handshake bookkeeping
  always_ff @(posedge SYSCLK or negedge reset_n) begin
    if (!reset_n) begin
      hs_fpga_r     <= '0;
      wr_buf_r      <= '0;
      byte_cnt_r    <= '0;
      word_cnt_r    <= '0;
      len_r         <= '0;
      shift_r       <= '0;
      end_pending_r <= 1'b0;
      we_r          <= 1'b0;
      dumpdone_r    <= 1'b0;
      busy_r        <= 1'b0;
      trashing_r    <= 1'b0;
      data_r        <= '0;
      addr_r        <= '0;
      dropped_r     <= 16'd0;
    end else begin
      we_r       <= 1'b0;
      dumpdone_r <= 1'b0;
      busy_r     <= (state_s != IDLE);
      trashing_r <= (state_s == TRASH);

      if (state_r == IDLE && state_s != IDLE) len_r <= frame_words;

      if (active_s && write_En_datachannel) begin
        shift_r <= packed_s;
        if (byte_cnt_r == BCW'(BPW - 1)) begin
          byte_cnt_r <= '0;
          word_cnt_r <= word_cnt_r + ADDR_W'(1);
          if (state_r == DUMPING) begin
            we_r   <= 1'b1;
            data_r <= packed_s;
            addr_r <= addr_s;
          end
          if (word_cnt_r == len_m1_s) end_pending_r <= 1'b1;
        end else begin
          byte_cnt_r <= byte_cnt_r + BCW'(1);
        end
      end

      if (state_s == STOPDUMP && state_r != STOPDUMP) begin
        dumpdone_r <= 1'b1;
        if (state_r == DUMPING) begin
          hs_fpga_r[wr_buf_r] <= ~hs_fpga_r[wr_buf_r];
          wr_buf_r            <= wr_buf_nxt_s;
        end else if (dropped_r != 16'hFFFF) begin
          dropped_r <= dropped_r + 16'd1;
        end
      end

      if (state_r == STOPDUMP) begin
        byte_cnt_r    <= '0;
        word_cnt_r    <= '0;
        shift_r       <= '0;
        end_pending_r <= 1'b0;
      end
    end
  end

  assign handshakeFPGA     = hs_fpga_r;
  assign IPbus_RAM_data    = data_r;
  assign IPbus_RAM_address = addr_r;
  assign IPbus_RAM_we      = we_r;
  assign dumpdone          = dumpdone_r;
  assign busy              = busy_r;
  assign trashing          = trashing_r;
  assign dropped_frames    = dropped_r;

endmodule

// File: tb/tb_frame_dump_mgr.sv
// Randomized self-checking bench for frame_dump_mgr against a frame-level reference model.
module tb_frame_dump_mgr;
  localparam int BPW = 4;
  localparam int WORD_W = 32;
  localparam int AW = 9;

  logic              SYSCLK = 1'b0;
  logic              reset_n;
  logic              dumpMem;
  logic              write_En_datachannel;
  logic [7:0]        data_datachannel;
  logic [7:0]        frame_words;
  logic [1:0]        handshakePC;
  logic [1:0]        handshakeFPGA;
  logic [WORD_W-1:0] IPbus_RAM_data;
  logic [AW-1:0]     IPbus_RAM_address;
  logic              IPbus_RAM_we;
  logic              dumpdone;
  logic              busy;
  logic              trashing;
  logic [15:0]       dropped_frames;

  always #5 SYSCLK = ~SYSCLK;

  frame_dump_mgr dut (
    .SYSCLK(SYSCLK), .reset_n(reset_n), .dumpMem(dumpMem),
    .write_En_datachannel(write_En_datachannel), .data_datachannel(data_datachannel),
    .frame_words(frame_words), .handshakePC(handshakePC), .handshakeFPGA(handshakeFPGA),
    .IPbus_RAM_data(IPbus_RAM_data), .IPbus_RAM_address(IPbus_RAM_address),
    .IPbus_RAM_we(IPbus_RAM_we), .dumpdone(dumpdone), .busy(busy),
    .trashing(trashing), .dropped_frames(dropped_frames)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Observed activity, sampled on the falling edge
  logic [AW-1:0]     got_addr[$];
  logic [WORD_W-1:0] got_data[$];
  int dd_cnt;
  bit trash_seen;

  always @(negedge SYSCLK) begin
    if (IPbus_RAM_we) begin
      got_addr.push_back(IPbus_RAM_address);
      got_data.push_back(IPbus_RAM_data);
    end
    if (dumpdone) dd_cnt = dd_cnt + 1;
    if (trashing) trash_seen = 1'b1;
  end

  // Reference model state
  logic [1:0] fpga_m;
  int wrbuf_m;
  int dropped_m;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic model_reset();
    fpga_m = 2'b00;
    wrbuf_m = 0;
    dropped_m = 0;
  endtask

  task automatic check_zero(input string name);
    cmp_cnt++;
    if ({handshakeFPGA, IPbus_RAM_data, IPbus_RAM_address, IPbus_RAM_we, dumpdone,
         busy, trashing, dropped_frames} !== '0) begin
      err_cnt++;
      $display("FAIL %s: outputs fpga=%b we=%b dd=%b busy=%b trash=%b drop=%0d addr=%h data=%h, required all zero",
               name, handshakeFPGA, IPbus_RAM_we, dumpdone, busy, trashing, dropped_frames,
               IPbus_RAM_address, IPbus_RAM_data);
    end
  endtask

  // One complete frame: trigger, bytes, wait for dumpdone, compare with model
  task automatic run_frame(input int len, input int gap_max, input bit noise, input bit seq);
    int nwords;
    int cyc;
    bit free_m;
    logic [7:0] bytes[$];
    logic [7:0] b;
    logic [WORD_W-1:0] exp_d;
    logic [AW-1:0] exp_a;
    nwords = (len == 0) ? 256 : len;
    free_m = (fpga_m[wrbuf_m] == handshakePC[wrbuf_m]);
    got_addr.delete();
    got_data.delete();
    dd_cnt = 0;
    trash_seen = 1'b0;
    if (noise) begin
      repeat (2) begin
        write_En_datachannel = 1'b1;
        data_datachannel = 8'($urandom);
        tick();
      end
    end
    dumpMem = 1'b1;
    frame_words = 8'(len);
    write_En_datachannel = noise;
    data_datachannel = 8'($urandom);
    tick();
    dumpMem = 1'b0;
    write_En_datachannel = 1'b0;
    for (int i = 0; i < nwords * BPW; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        write_En_datachannel = 1'b0;
        dumpMem = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        tick();
      end
      b = seq ? 8'(i + 1) : 8'($urandom);
      bytes.push_back(b);
      write_En_datachannel = 1'b1;
      data_datachannel = b;
      dumpMem = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      tick();
    end
    write_En_datachannel = 1'b0;
    dumpMem = 1'b0;
    cyc = 0;
    while (dd_cnt == 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    repeat (2) tick();

    cmp_cnt++;
    if (got_addr.size() !== (free_m ? nwords : 0)) begin
      err_cnt++;
      $display("FAIL write_count: got %0d writes, required %0d", got_addr.size(), free_m ? nwords : 0);
    end
    if (free_m) begin
      for (int w = 0; w < nwords && w < got_addr.size(); w++) begin
        exp_d = '0;
        for (int k = 0; k < BPW; k++) exp_d = (exp_d << 8) | WORD_W'(bytes[w*BPW + k]);
        exp_a = AW'(wrbuf_m * 256 + w);
        cmp_cnt++;
        if (got_addr[w] !== exp_a || got_data[w] !== exp_d) begin
          err_cnt++;
          $display("FAIL word%0d: got addr=%h data=%h, required addr=%h data=%h",
                   w, got_addr[w], got_data[w], exp_a, exp_d);
        end
      end
      fpga_m[wrbuf_m] = ~fpga_m[wrbuf_m];
      wrbuf_m = (wrbuf_m + 1) % 2;
    end else if (dropped_m < 65535) begin
      dropped_m++;
    end

    cmp_cnt++;
    if (dd_cnt !== 1) begin
      err_cnt++;
      $display("FAIL dumpdone: got %0d pulse cycles, required 1", dd_cnt);
    end
    cmp_cnt++;
    if (trash_seen !== !free_m) begin
      err_cnt++;
      $display("FAIL trashing: seen=%0b, required %0b", trash_seen, !free_m);
    end
    cmp_cnt++;
    if (handshakeFPGA !== fpga_m) begin
      err_cnt++;
      $display("FAIL handshakeFPGA: got %b, required %b", handshakeFPGA, fpga_m);
    end
    cmp_cnt++;
    if (dropped_frames !== 16'(dropped_m)) begin
      err_cnt++;
      $display("FAIL dropped_frames: got %0d, required %0d", dropped_frames, dropped_m);
    end
    cmp_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL busy_idle: got %b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    check_zero("reset_state");
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_basic();
    handshakePC = 2'b00;
    run_frame(2, 0, 1'b0, 1'b1);
  endtask

  task automatic test_trash();
    run_frame($urandom_range(4, 1), 1, 1'b0, 1'b0);
    run_frame($urandom_range(4, 1), 1, 1'b0, 1'b0);
  endtask

  task automatic test_pc_release();
    handshakePC = 2'b01;
    repeat (3) tick();
    run_frame(3, 1, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    handshakePC = 2'b11;
    repeat (3) tick();
    run_frame(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignore();
    handshakePC = 2'b00;
    repeat (3) tick();
    run_frame(3, 2, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      handshakePC = 2'($urandom_range(3, 0));
      repeat (3) tick();
      run_frame($urandom_range(5, 1), 2, 1'($urandom_range(1, 0)), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    handshakePC = fpga_m;
    repeat (3) tick();
    got_addr.delete();
    got_data.delete();
    dd_cnt = 0;
    dumpMem = 1'b1;
    frame_words = 8'd2;
    tick();
    dumpMem = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_En_datachannel = 1'b1;
      data_datachannel = 8'($urandom);
      tick();
    end
    write_En_datachannel = 1'b0;
    cmp_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL busy_midframe: got %b, required 1", busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("reset_midframe");
    tick();
    tick();
    reset_n = 1'b1;
    model_reset();
    handshakePC = 2'b00;
    repeat (3) tick();
    cmp_cnt++;
    if (got_addr.size() !== 0 || dd_cnt !== 0) begin
      err_cnt++;
      $display("FAIL abort_activity: got %0d writes %0d dumpdone, required 0 and 0", got_addr.size(), dd_cnt);
    end
    run_frame(2, 1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    dumpMem = 1'b0;
    write_En_datachannel = 1'b0;
    data_datachannel = 8'd0;
    frame_words = 8'd0;
    handshakePC = 2'b00;
    dd_cnt = 0;
    trash_seen = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_trash();
    test_pc_release();
    test_full();
    test_ignore();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
